// File: rtl/fnd_pkg.sv
// fnd_pkg: shared constants and helpers for the FND display blocks
package fnd_pkg;
    localparam int FND_DIGITS_4 = 4;
    localparam int FND_DIGITS_8 = 8;
    localparam logic [FND_DIGITS_8-1:0] COM_OFF = '1;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/tick_gen.sv
// tick_gen: enable-gated prescaler emitting a one-clock tick every CLK_HZ/TICK_HZ clocks
module tick_gen
    import fnd_pkg::*;
#(
    parameter int CLK_HZ  = 100_000_000,
    parameter int TICK_HZ = 1_000
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    output logic tick
);
    localparam int DIV = CLK_HZ / TICK_HZ;
    localparam int W   = clog2(DIV) > 0 ? clog2(DIV) : 1;
    logic [W-1:0] cnt;
    assign tick = en && cnt == W'(DIV - 1);
    always_ff @(posedge clk or posedge reset)
        if (reset) cnt <= '0;
        else if (en) cnt <= tick ? '0 : cnt + W'(1);
endmodule

// File: rtl/fnd_scan_ctrl.sv
// fnd_scan_ctrl: FND digit scan with dead-time blanking and leading-zero suppression
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int SCAN_HZ      = 1_000,
    parameter int NUM_DIGITS   = 4,
    parameter int SEL_W        = 3,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_enable,
    input  logic                  i_lz_en,
    input  logic [NUM_DIGITS-1:0] i_nz,
    input  logic [NUM_DIGITS-1:0] i_dp,
    output logic [SEL_W-1:0]      o_sel,
    output logic [NUM_DIGITS-1:0] o_com,
    output logic                  o_dp_n,
    output logic                  o_scan_tick
);
    localparam int BW = clog2(BLANK_CYCLES + 1) > 0 ? clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [NUM_DIGITS-1:0] OFF = COM_OFF[NUM_DIGITS-1:0];
    logic                  tick, en_q, suppress;
    logic [BW-1:0]         blank, blank_nx;
    logic [NUM_DIGITS-1:0] onehot, drive;
    logic [SEL_W-1:0]      sel_nx;
    tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(SCAN_HZ)) u_tick (
        .clk  (clk),
        .reset(reset),
        .en   (i_enable),
        .tick (tick)
    );
    always_comb begin
        onehot   = NUM_DIGITS'(1) << o_sel;
        suppress = i_lz_en && o_sel != '0 && (i_nz >> o_sel) == '0;
        drive    = suppress ? OFF : ~onehot;
        blank_nx = blank == '0 ? '0 : blank - BW'(1);
        sel_nx   = o_sel == SEL_W'(NUM_DIGITS - 1) ? '0 : o_sel + SEL_W'(1);
    end
    // the first enabled clock after idle reloads the blank counter, like a tick does
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            o_sel       <= '0;
            o_com       <= OFF;
            o_dp_n      <= 1'b1;
            o_scan_tick <= 1'b0;
            blank       <= BW'(BLANK_CYCLES);
            en_q        <= 1'b0;
        end else if (!i_enable) begin
            o_com       <= OFF;
            o_dp_n      <= 1'b1;
            o_scan_tick <= 1'b0;
            en_q        <= 1'b0;
        end else if (tick || !en_q) begin
            o_sel       <= tick ? sel_nx : o_sel;
            o_com       <= OFF;
            o_dp_n      <= 1'b1;
            o_scan_tick <= tick;
            blank       <= BW'(BLANK_CYCLES);
            en_q        <= 1'b1;
        end else begin
            o_com       <= blank_nx == '0 ? drive : OFF;
            o_dp_n      <= blank_nx == '0 ? ~|(i_dp & onehot) : 1'b1;
            o_scan_tick <= 1'b0;
            blank       <= blank_nx;
        end
    end
endmodule
